reg_file: RTL and testbench

- General-purpose integer register file for the RISC-V style datapath: 32 registers of 32 bits.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode (rs1/rs2/rd fields) and the ALU/writeback stage.
- Register x0 is hardwired to zero.

---
 rtl/reg_file_if.sv | 23 ++
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - decode/writeback bus for the integer register file
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              w_en;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (
    output w_en, rs1, rs2, rd, wd,
    input  rd1, rd2
  );

  modport slave (
    input  w_en, rs1, rs2, rd, wd,
    output rd1, rd2
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write integer register file with optional hardwired x0
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_if.slave   bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Slot i is real storage unless it is the hardwired zero register.
  function automatic logic is_storage(input int i);
    return !(ZERO_REG && (i == 0));
  endfunction

  // Address decode by comparison keeps out-of-range addresses inert on both paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.w_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (is_storage(i) && (bus.rd == ADDR_W'(i))) begin
          regs[i] <= bus.wd;
        end
      end
    end
  end

  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (is_storage(i) && (bus.rs1 == ADDR_W'(i))) begin
        bus.rd1 = regs[i];
      end
      if (is_storage(i) && (bus.rs2 == ADDR_W'(i))) begin
        bus.rd2 = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   cmp_on;

  logic [31:0] model [32];
  logic [31:0] tmp;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_REGS(32),
    .ZERO_REG(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: registers hold what was last written, x0 is always zero.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
    end else if (bus.w_en && bus.rd != 5'd0) begin
      model[bus.rd] <= bus.wd;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_rd1", bus.rd1, mread(bus.rs1));
      check("cmp_rd2", bus.rd2, mread(bus.rs2));
    end
  end

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.rd   = a;
    bus.wd   = d;
    bus.w_en = 1'b1;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    bus.rs1 = a1;
    bus.rs2 = a2;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cmp_on   = 1'b0;
    rst_n    = 1'b0;
    bus.w_en = 1'b0;
    bus.rs1  = '0;
    bus.rs2  = '0;
    bus.rd   = '0;
    bus.wd   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_reads(5'd0, 5'd17);
    check("reset_rd1_x0", bus.rd1, 32'd0);
    check("reset_rd2_x17", bus.rd2, 32'd0);
    cmp_on = 1'b1;

    // Add flow
    write_reg(5'd1, 32'd10);
    write_reg(5'd2, 32'd20);
    set_reads(5'd1, 5'd2);
    check("add_x1", bus.rd1, 32'd10);
    check("add_x2", bus.rd2, 32'd20);
    tmp = bus.rd1 + bus.rd2;
    write_reg(5'd3, tmp);
    set_reads(5'd3, 5'd3);
    check("add_x3", bus.rd1, 32'd30);
    check("add_same_port", bus.rd2, 32'd30);

    // Sub flow
    write_reg(5'd1, 32'd10);
    write_reg(5'd2, 32'd5);
    set_reads(5'd1, 5'd2);
    check("sub_x1", bus.rd1, 32'd10);
    check("sub_x2", bus.rd2, 32'd5);
    tmp = bus.rd1 - bus.rd2;
    write_reg(5'd3, tmp);
    set_reads(5'd3, 5'd2);
    check("sub_x3", bus.rd1, 32'd5);

    // x0 is hardwired and w_en gates writes
    write_reg(5'd0, 32'hDEADBEEF);
    set_reads(5'd0, 5'd0);
    check("x0_rd1", bus.rd1, 32'd0);
    check("x0_rd2", bus.rd2, 32'd0);
    bus.rd = 5'd4;
    bus.wd = 32'h1234;
    bus.w_en = 1'b0;
    @(posedge clk);
    #1;
    set_reads(5'd4, 5'd4);
    check("wen_low_x4", bus.rd1, 32'd0);

    // Full-width patterns at the top and middle of the address range
    write_reg(5'd31, 32'hFFFFFFFF);
    write_reg(5'd16, 32'hA5A5A5A5);
    set_reads(5'd31, 5'd16);
    check("x31_ones", bus.rd1, 32'hFFFFFFFF);
    check("x16_pattern", bus.rd2, 32'hA5A5A5A5);

    // Read-during-write returns old data until the edge
    write_reg(5'd5, 32'd7);
    bus.rs1  = 5'd5;
    bus.rd   = 5'd5;
    bus.wd   = 32'd9;
    bus.w_en = 1'b1;
    #1;
    check("rdw_before", bus.rd1, 32'd7);
    @(posedge clk);
    #1;
    check("rdw_after", bus.rd1, 32'd9);
    bus.w_en = 1'b0;

    // Asynchronous reset clears everything without a clock edge
    write_reg(5'd9, 32'h99);
    set_reads(5'd9, 5'd5);
    check("pre_reset_x9", bus.rd1, 32'h99);
    rst_n = 1'b0;
    #1;
    check("async_clear_x9", bus.rd1, 32'd0);
    check("async_clear_x5", bus.rd2, 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i));
      check("reset_sweep_rd1", bus.rd1, 32'd0);
      check("reset_sweep_rd2", bus.rd2, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset wins over a write on the same edge
    write_reg(5'd6, 32'h55);
    set_reads(5'd6, 5'd7);
    check("pre_x6", bus.rd1, 32'h55);
    bus.rd   = 5'd7;
    bus.wd   = 32'h66;
    bus.w_en = 1'b1;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    rst_n = 1'b1;
    set_reads(5'd6, 5'd7);
    check("midop_x6", bus.rd1, 32'd0);
    check("midop_x7", bus.rd2, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
